gcm_ctr_sched: RTL and testbench
================================

Name: gcm_ctr_sched

Overview:
- Sequencing controller for the 11-stage pipelined AES-128 encrypt core in the AES-GCM datapath.
- Per message it issues three kinds of block into the core:
  - all-zero block → hash subkey H;
  - J0 → E(K,J0), used as the tag mask;
  - num_blocks counter blocks inc32(J0)…
- The core has no backpressure, so returned keystream goes into an internal FIFO. Issue is credit-gated so that FIFO never overflows; the downstream GCTR XOR stage drains it via valid/ready.

Parameters:
- AES_LAT, 11, core latency from valid_in to valid_out (cycles).
- FIFO_DEPTH, 16, keystream FIFO entries (power of 2). Full throughput requires FIFO_DEPTH >= AES_LAT+3.
- CNT_W, 32, width of num_blocks and the internal block counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low; clears all state.
- start  in  1  one-cycle request; accepted only in IDLE.
- j0  in  128  pre-counter block, sampled on accepted start.
- num_blocks  in  CNT_W  number of keystream blocks, sampled on accepted start; 0 is legal.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at message completion.
- aes_pt  out  128  block to core plaintext (registered).
- aes_valid_in  out  1  issue strobe to core (registered).
- aes_ct  in  128  core ciphertext.
- aes_valid_out  in  1  core result strobe.
- h_out  out  128  H = E(K,0^128).
- h_valid  out  1  h_out valid; held until next accepted start.
- ekj0_out  out  128  E(K,J0).
- ekj0_valid  out  1  ekj0_out valid; held until next accepted start.
- ks_data  out  128  keystream block (FIFO head).
- ks_ctr  out  32  low 32 bits of the counter block that produced ks_data.
- ks_valid  out  1  FIFO non-empty.
- ks_ready  in  1  downstream pop; a pop occurs when ks_valid && ks_ready.

Behaviour:
- Reset values:
  - all outputs 0;
  - state = IDLE;
  - in_flight = 0, issue/return counters = 0;
  - FIFO empty.
- Reset asserted mid-message aborts immediately; no done is produced.
- FSM states: IDLE, ISSUE_H, ISSUE_J0, ISSUE_CTR, DRAIN.
  - IDLE: start=1 latches j0, num_blocks; clears h_valid and ekj0_valid; → ISSUE_H. start in any other state is ignored.
  - ISSUE_H: when credit is available, drive aes_pt=0^128, aes_valid_in=1; → ISSUE_J0.
  - ISSUE_J0: when credit is available, drive aes_pt=j0; ctr := j0; → ISSUE_CTR if num_blocks≠0, else DRAIN.
  - ISSUE_CTR: when credit is available:
    - ctr := {ctr[127:32], ctr[31:0]+1} (mod 2^32, upper 96 bits unchanged); drive aes_pt = new ctr;
    - push new ctr[31:0] into a side tag queue (depth FIFO_DEPTH) for ks_ctr;
    - after the num_blocks-th issue → DRAIN.
  - DRAIN: waits until all results have returned and the FIFO is empty (last block popped); then done=1 for one cycle → IDLE.
- Credit rule:
  - issue allowed iff in_flight + fifo_count < FIFO_DEPTH, using registered values (no same-cycle credit reuse);
  - in_flight increments on issue and decrements on aes_valid_out; simultaneous increment and decrement → unchanged.
- Cycle timing:
  - start accepted at cycle t → H issued at t+1, J0 at t+2, first counter at t+3;
  - with ks_ready=1, one issue per cycle thereafter.
- Return routing (in order, by return index):
  - index 0 → h_out, h_valid=1 the cycle after aes_valid_out;
  - index 1 → ekj0_out, ekj0_valid=1 the cycle after aes_valid_out;
  - index ≥2 → FIFO push.
- aes_valid_out while in_flight==0 (stale result from before a reset) is discarded.
- FIFO:
  - ks_valid rises the cycle after a push into an empty FIFO;
  - push and pop in the same cycle is legal and leaves the count unchanged;
  - overflow is unreachable by construction; verification asserts it.
- Widths: in_flight and fifo_count are clog2(FIFO_DEPTH)+1 bits; block counters are CNT_W bits.

Test Plan:
- AES core key=0, j0=000000000000000000000000_00000001, num_blocks=1, ks_ready=1 → aes_valid_in high at t+1..t+3; h_out=66e94bd4ef8a2c3b884cfa59ca342b2e; ekj0_out=58e2fccefa7e3061367f1d57a4e7455a; ks_data=0388dace60b6a392f328c2b971b2fe78 with ks_ctr=00000002; done once.
- num_blocks=0 → exactly 2 issues; h_valid and ekj0_valid set; ks_valid never high; done after the second return.
- j0 low word FFFFFFFE, num_blocks=3 → ks_ctr sequence FFFFFFFF, 00000000, 00000001; aes_pt[127:32] equals j0[127:32] on every counter issue.
- num_blocks=100, ks_ready=0 for 50 cycles then 1 → issues stall at in_flight+fifo_count=16; no overflow; all 100 blocks delivered in order with ks_ctr contiguous; done after the 100th pop.
- num_blocks=64, ks_ready=1 → after the first counter issue, aes_valid_in high every cycle (sustained 1 block/cycle).
- rst_n low mid-message, then start again → outputs zero during reset; stale aes_valid_out discarded; second message produces correct H, E(K,J0) and keystream.

Source files
------------

// File: rtl/gcm_ctr_sched_if.sv
// AES core and keystream FIFO handshake bundle for gcm_ctr_sched.
// master = the scheduler; slave = the AES core / GCTR XOR side.
interface gcm_ctr_sched_if;
  logic [127:0] aes_pt;
  logic         aes_valid_in;
  logic [127:0] aes_ct;
  logic         aes_valid_out;
  logic [127:0] ks_data;
  logic [31:0]  ks_ctr;
  logic         ks_valid;
  logic         ks_ready;

  modport master (
    output aes_pt, aes_valid_in, ks_data, ks_ctr, ks_valid,
    input  aes_ct, aes_valid_out, ks_ready
  );

  modport slave (
    input  aes_pt, aes_valid_in, ks_data, ks_ctr, ks_valid,
    output aes_ct, aes_valid_out, ks_ready
  );
endinterface

// File: rtl/gcm_ctr_sched.sv
// AES-GCM counter scheduler: issues 0^128, J0 and inc32 counter blocks into a
// pipelined AES core under credit control and buffers keystream in a FIFO.
module gcm_ctr_sched #(
  parameter int unsigned AES_LAT    = 11,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [127:0]       j0,
  input  logic [CNT_W-1:0]   num_blocks,
  output logic               busy,
  output logic               done,
  output logic [127:0]       h_out,
  output logic               h_valid,
  output logic [127:0]       ekj0_out,
  output logic               ekj0_valid,
  gcm_ctr_sched_if.master    bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < AES_LAT + 3) begin : g_rate_note
    $warning("gcm_ctr_sched: FIFO_DEPTH below AES_LAT+3 limits throughput");
  end

  typedef enum logic [2:0] {IDLE, ISSUE_H, ISSUE_J0, ISSUE_CTR, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [127:0]      ctr_q, ctr_d;
  logic [CNT_W-1:0]  nblk_q, nblk_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [1:0]        ret_idx_q, ret_idx_d;
  logic [PW-1:0]     in_flight_q, in_flight_d;
  logic [PW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     tag_wr_q, tag_wr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [127:0]      mem_q [FIFO_DEPTH];
  logic [127:0]      mem_d [FIFO_DEPTH];
  logic [31:0]       tag_q [FIFO_DEPTH];
  logic [31:0]       tag_d [FIFO_DEPTH];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [127:0]      aes_pt_q, aes_pt_d;
  logic              aes_valid_in_q, aes_valid_in_d;
  logic [127:0]      h_out_q, h_out_d;
  logic              h_valid_q, h_valid_d;
  logic [127:0]      ekj0_q, ekj0_d;
  logic              ekj0_valid_q, ekj0_valid_d;

  logic              issue, credit, ret_ok, push, pop;
  logic [PW:0]       occupancy;

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    nblk_d       = nblk_q;
    issued_d     = issued_q;
    ret_idx_d    = ret_idx_q;
    wr_ptr_d     = wr_ptr_q;
    tag_wr_d     = tag_wr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    tag_d        = tag_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aes_pt_d     = aes_pt_q;
    h_out_d      = h_out_q;
    h_valid_d    = h_valid_q;
    ekj0_d       = ekj0_q;
    ekj0_valid_d = ekj0_valid_q;
    issue        = 1'b0;
    push         = 1'b0;

    // Credit uses registered counts only, so a pop frees a slot one cycle later.
    occupancy = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
    credit    = occupancy < DEPTH_C;
    ret_ok    = bus.aes_valid_out && (in_flight_q != '0);
    pop       = (fifo_cnt_q != '0) && bus.ks_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ctr_d        = j0;
          nblk_d       = num_blocks;
          issued_d     = '0;
          ret_idx_d    = '0;
          h_valid_d    = 1'b0;
          ekj0_valid_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = ISSUE_H;
        end
      end
      ISSUE_H: begin
        if (credit) begin
          issue    = 1'b1;
          aes_pt_d = '0;
          state_d  = ISSUE_J0;
        end
      end
      ISSUE_J0: begin
        if (credit) begin
          issue    = 1'b1;
          aes_pt_d = ctr_q;
          state_d  = (nblk_q == '0) ? DRAIN : ISSUE_CTR;
        end
      end
      ISSUE_CTR: begin
        if (credit) begin
          issue           = 1'b1;
          ctr_d           = {ctr_q[127:32], ctr_q[31:0] + 32'd1};
          aes_pt_d        = ctr_d;
          tag_d[tag_wr_q] = ctr_d[31:0];
          tag_wr_d        = tag_wr_q + AW'(1);
          issued_d        = issued_q + CNT_W'(1);
          if (issued_d == nblk_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((in_flight_q == '0) && (fifo_cnt_q == '0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    aes_valid_in_d = issue;
    in_flight_d    = in_flight_q + PW'(issue) - PW'(ret_ok);

    // Results return in issue order: H, then E(K,J0), then keystream.
    if (ret_ok) begin
      unique case (ret_idx_q)
        2'd0: begin
          h_out_d   = bus.aes_ct;
          h_valid_d = 1'b1;
          ret_idx_d = 2'd1;
        end
        2'd1: begin
          ekj0_d       = bus.aes_ct;
          ekj0_valid_d = 1'b1;
          ret_idx_d    = 2'd2;
        end
        default: push = 1'b1;
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = bus.aes_ct;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    fifo_cnt_d = fifo_cnt_q + PW'(push) - PW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ctr_q          <= '0;
      nblk_q         <= '0;
      issued_q       <= '0;
      ret_idx_q      <= '0;
      in_flight_q    <= '0;
      fifo_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      tag_wr_q       <= '0;
      rd_ptr_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aes_pt_q       <= '0;
      aes_valid_in_q <= 1'b0;
      h_out_q        <= '0;
      h_valid_q      <= 1'b0;
      ekj0_q         <= '0;
      ekj0_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      nblk_q         <= nblk_d;
      issued_q       <= issued_d;
      ret_idx_q      <= ret_idx_d;
      in_flight_q    <= in_flight_d;
      fifo_cnt_q     <= fifo_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      tag_wr_q       <= tag_wr_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_q          <= mem_d;
      tag_q          <= tag_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aes_pt_q       <= aes_pt_d;
      aes_valid_in_q <= aes_valid_in_d;
      h_out_q        <= h_out_d;
      h_valid_q      <= h_valid_d;
      ekj0_q         <= ekj0_d;
      ekj0_valid_q   <= ekj0_valid_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign h_out            = h_out_q;
  assign h_valid          = h_valid_q;
  assign ekj0_out         = ekj0_q;
  assign ekj0_valid       = ekj0_valid_q;
  assign bus.aes_pt       = aes_pt_q;
  assign bus.aes_valid_in = aes_valid_in_q;
  assign bus.ks_data      = mem_q[rd_ptr_q];
  assign bus.ks_ctr       = tag_q[rd_ptr_q];
  assign bus.ks_valid     = (fifo_cnt_q != '0);

endmodule

// File: tb/tb_gcm_ctr_sched.sv
// Directed bench for gcm_ctr_sched with an 11-stage AES core stand-in that
// returns true AES-128 (key=0) results for 0, 1 and 2 and a fixed mix otherwise.
module tb_gcm_ctr_sched;
  localparam int unsigned LAT   = 11;
  localparam int unsigned DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         core_rst_n = 1'b0;
  logic         start;
  logic [127:0] j0;
  logic [31:0]  num_blocks;
  logic         busy, done, h_valid, ekj0_valid;
  logic [127:0] h_out, ekj0_out;

  gcm_ctr_sched_if bus ();

  gcm_ctr_sched #(.AES_LAT(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .j0(j0), .num_blocks(num_blocks),
    .busy(busy), .done(done), .h_out(h_out), .h_valid(h_valid),
    .ekj0_out(ekj0_out), .ekj0_valid(ekj0_valid), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    case (pt)
      128'h0: return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      128'h1: return 128'h58e2fccefa7e3061367f1d57a4e7455a;
      128'h2: return 128'h0388dace60b6a392f328c2b971b2fe78;
      default: return {pt[63:0], pt[127:64]} ^ {4{32'h9E3779B9}};
    endcase
  endfunction

  // Core stand-in: not reset with the DUT, so pre-reset results still emerge.
  logic [LAT-1:0] pv;
  logic [127:0]   pp [LAT];
  always @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pp[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus.aes_valid_in};
      pp[0] <= bus.aes_pt;
      for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
    end
  end
  assign bus.aes_valid_out = pv[LAT-1];
  assign bus.aes_ct        = aes_model(pp[LAT-1]);

  int checks = 0;
  int failures = 0;

  int iss, pops, done_cnt, max_occ, first_iss, first_ctr, last_iss, last_pop, done_cyc;
  bit ks_seen;
  logic [127:0] cap_h, cap_e;
  logic [127:0] iss_pt [$];
  logic [127:0] got_data [$];
  logic [31:0]  got_ctr [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one message and observes it; cycle k=0 is just after the accepting edge.
  task automatic run_msg(input logic [127:0] jv, input logic [31:0] nb, input int hold, input int max_cyc);
    int hj, rets, occ;
    hj = 0; rets = 0;
    iss = 0; pops = 0; done_cnt = 0; max_occ = 0;
    first_iss = -1; first_ctr = -1; last_iss = -1; last_pop = -1; done_cyc = -1;
    ks_seen = 1'b0; cap_h = '0; cap_e = '0;
    iss_pt.delete(); got_data.delete(); got_ctr.delete();
    bus.ks_ready = (hold == 0);
    j0 = jv; num_blocks = nb; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (k >= hold) bus.ks_ready = 1'b1;
      if (bus.aes_valid_in) begin
        iss++;
        iss_pt.push_back(bus.aes_pt);
        if (first_iss < 0) first_iss = k;
        if (iss == 3) first_ctr = k;
        last_iss = k;
      end
      occ = iss - hj - pops;
      if (occ > max_occ) max_occ = occ;
      if (bus.aes_valid_out) begin
        if (rets < 2) hj++;
        rets++;
      end
      if (bus.ks_valid) ks_seen = 1'b1;
      if (bus.ks_valid && bus.ks_ready) begin
        got_data.push_back(bus.ks_data);
        got_ctr.push_back(bus.ks_ctr);
        pops++;
        last_pop = k;
      end
      if (h_valid) cap_h = h_out;
      if (ekj0_valid) cap_e = ekj0_out;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
      step();
    end
  endtask

  logic [127:0] jv;
  logic [31:0]  c;
  int err, stale, bad;

  initial begin
    start = 1'b0; j0 = '0; num_blocks = '0; bus.ks_ready = 1'b0;
    step();
    check("reset_ctrl", {busy, done, h_valid, ekj0_valid, bus.aes_valid_in, bus.ks_valid}, 6'b0);
    check("reset_data", bus.aes_pt | h_out | ekj0_out | bus.ks_data, '0);
    check("reset_ks_ctr", bus.ks_ctr, 32'h0);
    step(); step();
    rst_n = 1'b1; core_rst_n = 1'b1;
    step();

    // Known-answer message, one block.
    run_msg(128'h1, 32'd1, 0, 80);
    check("t1_done_seen", done_cyc >= 0, 1'b1);
    check("t1_issues", iss, 3);
    check("t1_first_issue", first_iss, 1);
    check("t1_last_issue", last_iss, 3);
    check("t1_h", cap_h, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    check("t1_ekj0", cap_e, 128'h58e2fccefa7e3061367f1d57a4e7455a);
    check("t1_pops", pops, 1);
    check("t1_ks_data", got_data[0], 128'h0388dace60b6a392f328c2b971b2fe78);
    check("t1_ks_ctr", got_ctr[0], 32'h00000002);
    check("t1_pop_cycle", last_pop, 15);
    check("t1_done_cycle", done_cyc, 17);
    check("t1_done_count", done_cnt, 1);
    check("t1_busy_after", busy, 1'b0);

    // Zero keystream blocks.
    jv = 128'h11223344_55667788_99aabbcc_00000007;
    run_msg(jv, 32'd0, 0, 80);
    check("t2_issues", iss, 2);
    check("t2_h", cap_h, aes_model(128'h0));
    check("t2_ekj0", cap_e, aes_model(jv));
    check("t2_ks_never_valid", ks_seen, 1'b0);
    check("t2_done_cycle", done_cyc, 15);
    check("t2_done_count", done_cnt, 1);

    // inc32 wraps only the low word.
    jv = 128'hcafebabe_deadbeef_01234567_fffffffe;
    run_msg(jv, 32'd3, 0, 80);
    check("t3_issues", iss, 5);
    check("t3_pops", pops, 3);
    for (int i = 0; i < 3; i++) begin
      c = 32'hffffffff + 32'(i);
      check("t3_pt_upper", iss_pt[2+i][127:32], jv[127:32]);
      check("t3_pt_low", iss_pt[2+i][31:0], c);
      check("t3_ks_ctr", got_ctr[i], c);
      check("t3_ks_data", got_data[i], aes_model({jv[127:32], c}));
    end

    // Backpressure: downstream stalls for 50 cycles.
    jv = 128'h0f0e0d0c_0b0a0908_07060504_00001000;
    run_msg(jv, 32'd100, 50, 600);
    check("t4_done_seen", done_cyc >= 0, 1'b1);
    check("t4_max_occupancy", max_occ, DEPTH);
    check("t4_issues", iss, 102);
    check("t4_pops", pops, 100);
    err = 0;
    for (int i = 0; i < got_ctr.size(); i++) begin
      c = jv[31:0] + 32'd1 + 32'(i);
      if (got_ctr[i] !== c || got_data[i] !== aes_model({jv[127:32], c})) err++;
    end
    check("t4_order_errors", err, 0);
    check("t4_done_after_pop", done_cyc > last_pop, 1'b1);
    check("t4_done_count", done_cnt, 1);

    // Sustained throughput.
    jv = 128'h01010101_02020202_03030303_00000100;
    run_msg(jv, 32'd64, 0, 200);
    check("t5_issues", iss, 66);
    check("t5_gaps", (last_iss - first_ctr + 1) - (iss - 2), 0);
    check("t5_pops", pops, 64);
    check("t5_last_ctr", got_ctr[63], jv[31:0] + 32'd64);
    check("t5_done_count", done_cnt, 1);

    // Reset in the middle of a message, then a clean message.
    j0 = 128'h01234567_89abcdef_01234567_00000010; num_blocks = 32'd20;
    bus.ks_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {busy, done, h_valid, ekj0_valid, bus.aes_valid_in, bus.ks_valid}, 6'b0);
    check("t6_rst_data", bus.aes_pt | h_out | ekj0_out | bus.ks_data, '0);
    repeat (3) step();
    rst_n = 1'b1;
    stale = 0; bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.aes_valid_out) stale++;
      if (h_valid | ekj0_valid | bus.ks_valid | done | busy | bus.aes_valid_in) bad++;
      step();
    end
    check("t6_stale_returns", stale, 6);
    check("t6_stale_ignored", bad, 0);
    run_msg(128'h1, 32'd1, 0, 80);
    check("t6_h", cap_h, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    check("t6_ekj0", cap_e, 128'h58e2fccefa7e3061367f1d57a4e7455a);
    check("t6_ks_data", got_data[0], 128'h0388dace60b6a392f328c2b971b2fe78);
    check("t6_ks_ctr", got_ctr[0], 32'h00000002);
    check("t6_done_count", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
